// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared fetch-stage types and constants
package fetch_stage_pkg;

    localparam int XLEN = 16;
    localparam logic [XLEN-1:0] PC_INC = 16'd2;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_fifo.sv
// rtl/fetch_stage_fifo.sv - circular instruction buffer holding {instruction, pc_plus2}
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_push = push & (~full | pop) & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage; contents are only observable while counted as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner and imem fetcher feeding decode; option macro FETCH_ALIGN_CHK_EN
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] pc_plus2,
    output logic            err
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e      state_q;
    logic [XLEN-1:0]   pc_q;
    logic              halt_pend_q;

    logic              outstanding;
    logic              active;
    logic              rvalid_accept;
    logic              pop;
    logic              flush;
    logic              stop;
    logic              align_fault;
    logic              issue_ok;
    logic              req_fire;
    logic [XLEN-1:0]   target_pc;
    logic [CW:0]       occ;

    logic              fifo_push;
    logic [2*XLEN-1:0] fifo_head;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    assign outstanding   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    assign active        = (state_q == ST_RUN) || (state_q == ST_WAIT);
    assign rvalid_accept = imem_rvalid & (state_q == ST_WAIT);
    assign pop           = inst_valid & inst_ready;
    assign flush         = halt | redirect;
    assign target_pc     = redirect_pc & 16'hFFFE;

`ifdef FETCH_ALIGN_CHK_EN
    logic err_q;

    assign align_fault = redirect & redirect_pc[0] & (state_q != ST_HALTED);
    assign err         = err_q;

    // Sticky error on a misaligned redirect; a concurrent halt takes precedence.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_q | (align_fault & ~halt);
    end
`else
    assign align_fault = 1'b0;
    assign err         = 1'b0;
`endif

    assign stop = halt | align_fault;

    // Occupancy after this cycle: a returning response moves from outstanding into the
    // FIFO, so it is counted once; a slot is reserved for every request in flight.
    assign occ      = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding} - {{CW{1'b0}}, pop};
    assign issue_ok = (occ < (CW+1)'(DEPTH));

    assign imem_req  = rst & active & issue_ok & ~redirect & ~halt;
    assign imem_addr = pc_q;
    assign req_fire  = imem_req & imem_ready;

    // At response time the PC already points past the fetched word, so it is addr+2.
    assign fifo_push = rvalid_accept & ~flush & (~fifo_full | pop);

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (fifo_push),
        .push_data ({imem_rdata, pc_q}),
        .pop       (pop),
        .flush     (flush),
        .head_data (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign inst_valid  = ~fifo_empty;
    assign instruction = inst_valid ? fifo_head[2*XLEN-1:XLEN] : '0;
    assign pc_plus2    = inst_valid ? fifo_head[XLEN-1:0]      : '0;

    // Fetch FSM: PC advance, redirect/halt handling and stale-response draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            halt_pend_q <= 1'b0;
        end else begin
            case (state_q)
                ST_HALTED: begin
                end
                default: begin
                    if (stop) begin
                        if (outstanding && !imem_rvalid) begin
                            state_q     <= ST_DRAIN;
                            halt_pend_q <= 1'b1;
                        end else begin
                            state_q <= ST_HALTED;
                        end
                    end else if (redirect) begin
                        pc_q <= target_pc;
                        if (outstanding && !imem_rvalid) state_q <= ST_DRAIN;
                        else if (halt_pend_q)            state_q <= ST_HALTED;
                        else                             state_q <= ST_RUN;
                    end else if (state_q == ST_DRAIN) begin
                        if (imem_rvalid) state_q <= halt_pend_q ? ST_HALTED : ST_RUN;
                    end else if (req_fire) begin
                        pc_q    <= pc_q + PC_INC;
                        state_q <= ST_WAIT;
                    end else if (rvalid_accept) begin
                        state_q <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0;
    logic        halt = 1'b0;
    logic        inst_ready = 1'b1;

    logic        imem_req,   imem_req_w;
    logic [15:0] imem_addr,  imem_addr_w;
    logic        inst_valid, inst_valid_w;
    logic [15:0] instruction, instruction_w;
    logic [15:0] pc_plus2,   pc_plus2_w;
    logic        err,        err_w;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .instruction(instruction),
        .pc_plus2(pc_plus2), .err(err)
    );

    fetch_stage #(.RESET_PC(16'hFFFE), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
        .inst_valid(inst_valid_w), .inst_ready(inst_ready), .instruction(instruction_w),
        .pc_plus2(pc_plus2_w), .err(err_w)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];

    bit          pend_valid = 0;
    bit          pend_stale = 0;
    logic [15:0] pend_addr = 16'h0;
    int          pend_cnt = 0;
    int          mem_delay = 1;

    bit          last_req, last_acc, popped;
    logic [15:0] last_addr, last_addr_w, pop_pcp2;

    // One clock of stimulus: memory model, scoreboard pop/compare, request capture.
    task automatic step(input logic rdy, input logic red, input logic hlt, input logic [15:0] rpc);
        bit          deliver;
        logic [31:0] e;
        @(negedge clk);
        inst_ready  = rdy;
        redirect    = red;
        halt        = hlt;
        redirect_pc = rpc;
        imem_ready  = 1'b1;
        deliver     = pend_valid && (pend_cnt == 0);
        imem_rvalid = deliver;
        imem_rdata  = deliver ? pend_addr : 16'h0;
        #1;
        popped = 0;
        if (inst_valid && inst_ready) begin
            popped   = 1;
            pop_pcp2 = pc_plus2;
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got instruction=%h pc_plus2=%h, required no valid entry", instruction, pc_plus2);
            end else begin
                e = exp_q.pop_front();
                if ({instruction, pc_plus2} !== e)
                    $display("FAIL sb_order: got %h/%h, required %h/%h", instruction, pc_plus2, e[31:16], e[15:0]);
                else
                    n_pass++;
            end
        end
        if (deliver) begin
            pend_valid = 0;
            if (!pend_stale && !red && !hlt) exp_q.push_back({pend_addr, pend_addr + 16'd2});
        end
        if (red || hlt) begin
            exp_q.delete();
            if (pend_valid) pend_stale = 1;
        end
        if (pend_valid) pend_cnt--;
        last_req    = imem_req;
        last_acc    = imem_req && imem_ready;
        last_addr   = imem_addr;
        last_addr_w = imem_addr_w;
        if (last_acc) begin
            n_checks++;
            if (pend_valid) $display("FAIL one_outstanding: got a second request at %h, required none", imem_addr);
            else            n_pass++;
            pend_valid = 1;
            pend_addr  = imem_addr;
            pend_cnt   = mem_delay - 1;
            pend_stale = 0;
        end
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b0;
        inst_ready = 1'b1; redirect = 1'b0; halt = 1'b0; redirect_pc = 16'h0;
        imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = 16'h0;
        pend_valid = 0; pend_stale = 0; mem_delay = 1;
        exp_q.delete();
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        hold_reset();
        n_checks++; if (imem_req !== 1'b0)       $display("FAIL rst_req: got %b required 0", imem_req); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0)     $display("FAIL rst_valid: got %b required 0", inst_valid); else n_pass++;
        n_checks++; if (instruction !== 16'h0)   $display("FAIL rst_instr: got %h required 0000", instruction); else n_pass++;
        n_checks++; if (pc_plus2 !== 16'h0)      $display("FAIL rst_pcp2: got %h required 0000", pc_plus2); else n_pass++;
        n_checks++; if (err !== 1'b0)            $display("FAIL rst_err: got %b required 0", err); else n_pass++;
        n_checks++; if (imem_addr !== 16'h0000)  $display("FAIL rst_pc: got %h required 0000", imem_addr); else n_pass++;
        n_checks++; if (imem_addr_w !== 16'hFFFE) $display("FAIL rst_pc_w: got %h required fffe", imem_addr_w); else n_pass++;
        n_checks++; if (imem_req_w !== 1'b0)     $display("FAIL rst_req_w: got %b required 0", imem_req_w); else n_pass++;
        release_reset();
    endtask

    task automatic test_stream();
        int pops = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (popped) pops++;
            if (i < 8) begin
                n_checks++;
                if (!last_acc || last_addr !== 16'(2*i))
                    $display("FAIL stream_addr%0d: got req=%b addr=%h required req=1 addr=%h", i, last_acc, last_addr, 16'(2*i));
                else n_pass++;
            end
            if (i == 0) begin
                n_checks++; if (last_addr_w !== 16'hFFFE) $display("FAIL wrap_addr0: got %h required fffe", last_addr_w); else n_pass++;
            end
            if (i == 1) begin
                n_checks++; if (last_addr_w !== 16'h0000) $display("FAIL wrap_addr1: got %h required 0000", last_addr_w); else n_pass++;
                n_checks++; if (inst_valid !== 1'b0) $display("FAIL stream_latency: got valid=%b at cycle 1 required 0", inst_valid); else n_pass++;
            end
            if (i == 2) begin
                n_checks++; if (pc_plus2_w !== 16'h0000) $display("FAIL wrap_pcp2: got %h required 0000", pc_plus2_w); else n_pass++;
                n_checks++; if (inst_valid !== 1'b1) $display("FAIL stream_first: got valid=%b at cycle 2 required 1", inst_valid); else n_pass++;
            end
        end
        n_checks++; if (pops != 18) $display("FAIL stream_rate: got %0d pops required 18", pops); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 16'h0);
        n_checks++; if (last_req !== 1'b0) $display("FAIL stall_req: got %b required 0", last_req); else n_pass++;
        n_checks++; if (exp_q.size() != 2) $display("FAIL stall_depth: got %0d buffered required 2", exp_q.size()); else n_pass++;
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL stall_valid: got %b required 1", inst_valid); else n_pass++;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
    endtask

    task automatic test_redirect_drain();
        bit got = 0;
        bit acc_seen = 0;
        mem_delay = 3;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            got = last_acc;
        end
        n_checks++; if (!got) $display("FAIL redir_setup: got no request within 10 cycles required one"); else n_pass++;
        step(1'b1, 1'b1, 1'b0, 16'h0100);
        mem_delay = 1;
        @(posedge clk); #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL redir_flush: got valid=%b required 0", inst_valid); else n_pass++;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (last_acc && !acc_seen) begin
                acc_seen = 1;
                n_checks++; if (last_addr !== 16'h0100) $display("FAIL redir_addr: got %h required 0100", last_addr); else n_pass++;
            end
            if (popped) begin
                got = 1;
                n_checks++; if (pop_pcp2 !== 16'h0102) $display("FAIL redir_pcp2: got %h required 0102", pop_pcp2); else n_pass++;
            end
        end
        n_checks++; if (!got) $display("FAIL redir_timeout: got no instruction within 20 cycles required one"); else n_pass++;
    endtask

    task automatic test_halt();
        int reqs = 0;
        step(1'b1, 1'b1, 1'b1, 16'h0200);
        @(posedge clk); #1;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL halt_flush: got valid=%b required 0", inst_valid); else n_pass++;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (last_req) reqs++;
        end
        n_checks++; if (reqs != 0) $display("FAIL halt_req: got %0d requests required 0", reqs); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL halt_valid: got %b required 0", inst_valid); else n_pass++;
    endtask

    task automatic test_align();
        bit got = 0;
        hold_reset();
        release_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 16'h0);
        step(1'b1, 1'b1, 1'b0, 16'h0013);
`ifdef FETCH_ALIGN_CHK_EN
        @(posedge clk); #1;
        n_checks++; if (err !== 1'b1) $display("FAIL align_err: got %b required 1", err); else n_pass++;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            if (last_req) got = 1;
        end
        n_checks++; if (got) $display("FAIL align_noreq: got a request after misaligned redirect required none"); else n_pass++;
`else
        for (int i = 0; i < 10 && !got; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'h0);
            got = last_acc;
        end
        n_checks++; if (!got || last_addr !== 16'h0012) $display("FAIL align_addr: got req=%b addr=%h required 0012", got, last_addr); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL align_err: got %b required 0", err); else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_drain();
        test_halt();
        test_align();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
